apb2ahb_bridge: RTL and testbench

APB2AHB_BRIDGE -- requirements
Module: apb2ahb_bridge

---
 rtl/amba_pkg.sv | 31 +++
 rtl/apb2ahb_bridge_if.sv | 51 +++++
 rtl/apb2ahb_bridge.sv | 98 +++++++++
 tb/tb_apb2ahb_bridge.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// Shared AMBA encodings and the bridge FSM state type.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package amba_pkg;

    // One transfer outstanding: capture, AHB address phase, AHB data phase, APB completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // APB setup phase seen on an enabled APB edge.
    function automatic logic apb_setup(input logic pclken, input logic psel, input logic penable);
        return pclken & psel & ~penable;
    endfunction

    // APB access phase seen on an enabled APB edge.
    function automatic logic apb_access(input logic pclken, input logic psel, input logic penable);
        return pclken & psel & penable;
    endfunction

endpackage

// File: rtl/apb2ahb_bridge_if.sv
// Bundle of APB3 completer and AHB-Lite manager signals around the bridge.
// Latency: none (wiring only).
// Backpressure: PREADY towards APB, HREADY from AHB.
interface apb2ahb_bridge_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    // APB side
    logic                 PCLKEN;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;
    // AHB side
    logic [ADDRWIDTH-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [3:0]           HPROT;
    logic                 HMASTLOCK;
    logic [DATAWIDTH-1:0] HWDATA;
    logic [DATAWIDTH-1:0] HRDATA;
    logic                 HREADY;
    logic                 HRESP;
    // Status
    logic                 APBACTIVE;

    // Bridge view: APB completer, AHB manager.
    modport slave (
        input  PCLKEN, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP,
        output APBACTIVE
    );

    // Environment view: APB requester, AHB subordinate.
    modport master (
        output PCLKEN, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP,
        input  APBACTIVE
    );

endinterface

// File: rtl/apb2ahb_bridge.sv
// APB3 completer to AHB-Lite manager bridge, one single-beat word transfer at a time.
// Latency: setup edge T, AHB address phase T+1, data phase T+2, PREADY high T+3; +1 per AHB wait state.
// Backpressure: PREADY held low until the AHB data phase completes; AHB waits stall the FSM via HREADY.
module apb2ahb_bridge
    import amba_pkg::*;
#(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    apb2ahb_bridge_if.slave   bus
);

    bridge_state_t        state;
    logic [ADDRWIDTH-1:0] cap_addr;
    logic                 cap_write;
    logic [DATAWIDTH-1:0] cap_wdata;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 err_q;
    logic                 pready_q;
    logic                 active_q;
    logic [1:0]           htrans_q;

    // Single FSM: APB capture and release are PCLKEN-qualified, AHB phases advance every HCLK.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            active_q  <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (apb_setup(bus.PCLKEN, bus.PSEL, bus.PENABLE)) begin
                        state     <= ST_ADDR;
                        cap_addr  <= bus.PADDR;
                        cap_write <= bus.PWRITE;
                        cap_wdata <= bus.PWDATA;
                        htrans_q  <= HTRANS_NONSEQ;
                        active_q  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    // Address accepted once the previous data phase (if any) is ready.
                    if (bus.HREADY) begin
                        state    <= ST_DATA;
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                ST_DATA: begin
                    // First ERROR cycle has HREADY low and simply holds here; the
                    // second cycle (HREADY high) is where HRESP gets latched.
                    if (bus.HREADY) begin
                        state    <= ST_DONE;
                        err_q    <= bus.HRESP;
                        pready_q <= 1'b1;
                        if (!cap_write) begin
                            rdata_q <= bus.HRDATA;
                        end
                    end
                end
                ST_DONE: begin
                    // Only a proper access phase releases DONE; a dropped PSEL or a
                    // fresh setup here is ignored so no new transfer is captured.
                    if (apb_access(bus.PCLKEN, bus.PSEL, bus.PENABLE)) begin
                        state    <= ST_IDLE;
                        err_q    <= 1'b0;
                        pready_q <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PRDATA    = rdata_q;
    assign bus.PREADY    = pready_q;
    assign bus.PSLVERR   = err_q & pready_q;
    assign bus.HADDR     = cap_addr;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = cap_write;
    assign bus.HWDATA    = cap_wdata;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DEFAULT;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.APBACTIVE = active_q;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Directed bench for apb2ahb_bridge: APB requester and AHB responder driven cycle by cycle.
// Latency: expected cycle positions are hand-derived from the setup edge.
// Backpressure: HREADY wait states and PCLKEN gaps are inserted explicitly per scenario.
module tb_apb2ahb_bridge;

    logic HCLK;
    logic HRESETn;
    int   n_total;
    int   n_bad;

    apb2ahb_bridge_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

    apb2ahb_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // One APB transfer with PCLKEN held high; waits = AHB data-phase wait states.
    // err gives a two-cycle ERROR in the data phase (needs waits >= 1).
    // stall drops PSEL, then offers a fresh setup, while in DONE before the access completes.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic err,
                        input logic [31:0] exp_rdata, input logic stall);
        cyc();
        bus.PCLKEN = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wd;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = rd;
        @(negedge HCLK);
        chk("setup_active", bus.APBACTIVE, 0);
        chk("setup_pready", bus.PREADY, 0);
        cyc();
        bus.PENABLE = 1'b1;
        @(negedge HCLK);
        chk("addr_htrans", bus.HTRANS, 2'b10);
        chk("addr_haddr", bus.HADDR, addr);
        chk("addr_hwrite", bus.HWRITE, wr);
        chk("addr_active", bus.APBACTIVE, 1);
        chk("addr_pready", bus.PREADY, 0);
        cyc();
        for (int i = 0; i < waits; i++) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = err && (i == waits - 1);
            @(negedge HCLK);
            chk("wait_htrans", bus.HTRANS, 2'b00);
            chk("wait_haddr", bus.HADDR, addr);
            chk("wait_pready", bus.PREADY, 0);
            cyc();
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = err;
        @(negedge HCLK);
        chk("data_htrans", bus.HTRANS, 2'b00);
        chk("data_hwdata", bus.HWDATA, wd);
        chk("data_hwrite", bus.HWRITE, wr);
        chk("data_pready", bus.PREADY, 0);
        cyc();
        bus.HRESP  = 1'b0;
        bus.HRDATA = ~rd;
        if (stall) begin
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
            @(negedge HCLK);
            chk("stall_pready0", bus.PREADY, 1);
            cyc();
            bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 16'h0999;
            @(negedge HCLK);
            chk("stall_pready1", bus.PREADY, 1);
            cyc();
            bus.PADDR = addr; bus.PENABLE = 1'b1;
        end
        @(negedge HCLK);
        chk("done_pready", bus.PREADY, 1);
        chk("done_pslverr", bus.PSLVERR, err);
        chk("done_prdata", bus.PRDATA, exp_rdata);
        chk("done_haddr", bus.HADDR, addr);
        chk("done_active", bus.APBACTIVE, 1);
        cyc();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge HCLK);
        chk("idle_pready", bus.PREADY, 0);
        chk("idle_pslverr", bus.PSLVERR, 0);
        chk("idle_active", bus.APBACTIVE, 0);
        chk("idle_htrans", bus.HTRANS, 2'b00);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        HRESETn = 1'b0;
        bus.PCLKEN = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

        // Reset state and constant AHB attributes.
        #3;
        chk("rst_pready", bus.PREADY, 0);
        chk("rst_pslverr", bus.PSLVERR, 0);
        chk("rst_prdata", bus.PRDATA, 0);
        chk("rst_htrans", bus.HTRANS, 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwrite", bus.HWRITE, 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_active", bus.APBACTIVE, 0);
        chk("const_hsize", bus.HSIZE, 3'b010);
        chk("const_hburst", bus.HBURST, 3'b000);
        chk("const_hprot", bus.HPROT, 4'b0011);
        chk("const_hmastlock", bus.HMASTLOCK, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Zero-wait write.
        xfer(1'b1, 16'h0040, 32'hDEADBEEF, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        // Read with three AHB wait states.
        xfer(1'b0, 16'h0044, 32'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0);
        // Write with two-cycle ERROR; PRDATA keeps the last read value.
        xfer(1'b1, 16'h0048, 32'h0BADF00D, 1, 32'h55AA55AA, 1'b1, 32'h12345678, 1'b0);
        // Read with PSEL dropped and a stray setup while in DONE.
        xfer(1'b0, 16'h004C, 32'h0, 0, 32'h87654321, 1'b0, 32'h87654321, 1'b1);

        // PCLKEN on alternate cycles: read then write, back to back.
        cyc();
        bus.PCLKEN = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 16'h0100; bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hA5A50F0F;
        @(negedge HCLK); chk("pc_c0_active", bus.APBACTIVE, 0);
        cyc(); bus.PCLKEN = 1'b1;
        @(negedge HCLK); chk("pc_rd_nosample", bus.APBACTIVE, 0);
        cyc(); bus.PCLKEN = 1'b0; bus.PENABLE = 1'b1;
        @(negedge HCLK); chk("pc_rd_htrans", bus.HTRANS, 2'b10); chk("pc_rd_haddr", bus.HADDR, 16'h0100);
        cyc(); bus.PCLKEN = 1'b1;
        @(negedge HCLK); chk("pc_rd_data_htrans", bus.HTRANS, 2'b00); chk("pc_rd_data_pready", bus.PREADY, 0);
        cyc(); bus.PCLKEN = 1'b0; bus.HRDATA = 32'h0;
        @(negedge HCLK); chk("pc_rd_pready", bus.PREADY, 1); chk("pc_rd_prdata", bus.PRDATA, 32'hA5A50F0F);
        cyc(); bus.PCLKEN = 1'b1;
        @(negedge HCLK); chk("pc_rd_hold", bus.PREADY, 1);
        cyc(); bus.PCLKEN = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 16'h0200; bus.PWDATA = 32'hCAFEF00D;
        @(negedge HCLK); chk("pc_rd_release", bus.PREADY, 0); chk("pc_wr_c6_active", bus.APBACTIVE, 0);
        cyc(); bus.PCLKEN = 1'b1;
        @(negedge HCLK); chk("pc_wr_nosample", bus.APBACTIVE, 0);
        cyc(); bus.PCLKEN = 1'b0; bus.PENABLE = 1'b1;
        @(negedge HCLK); chk("pc_wr_htrans", bus.HTRANS, 2'b10); chk("pc_wr_hwrite", bus.HWRITE, 1);
        chk("pc_wr_haddr", bus.HADDR, 16'h0200);
        cyc(); bus.PCLKEN = 1'b1; bus.HRDATA = 32'hFFFF0000;
        @(negedge HCLK); chk("pc_wr_hwdata", bus.HWDATA, 32'hCAFEF00D);
        cyc(); bus.PCLKEN = 1'b0;
        @(negedge HCLK); chk("pc_wr_pready", bus.PREADY, 1); chk("pc_wr_prdata", bus.PRDATA, 32'hA5A50F0F);
        chk("pc_wr_pslverr", bus.PSLVERR, 0);
        cyc(); bus.PCLKEN = 1'b1;
        @(negedge HCLK); chk("pc_wr_hold", bus.PREADY, 1);
        cyc(); bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge HCLK); chk("pc_wr_release", bus.PREADY, 0); chk("pc_wr_idle_active", bus.APBACTIVE, 0);

        // Reset asserted during the AHB data phase.
        cyc();
        bus.PCLKEN = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 16'h0300; bus.PWDATA = 32'h13579BDF; bus.HREADY = 1'b1;
        cyc(); bus.PENABLE = 1'b1;
        cyc(); bus.HREADY = 1'b0;
        @(negedge HCLK); chk("rr_pre_active", bus.APBACTIVE, 1);
        #1 HRESETn = 1'b0;
        #1;
        chk("rr_pready", bus.PREADY, 0);
        chk("rr_active", bus.APBACTIVE, 0);
        chk("rr_htrans", bus.HTRANS, 0);
        chk("rr_haddr", bus.HADDR, 0);
        chk("rr_hwdata", bus.HWDATA, 0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge HCLK);
            chk("rr_after_pready", bus.PREADY, 0);
            chk("rr_after_active", bus.APBACTIVE, 0);
        end
        xfer(1'b0, 16'h0304, 32'h0, 0, 32'h2468ACE0, 1'b0, 32'h2468ACE0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
